// File: rtl/simple_bus_mem_ctrl_if.sv
// simple_bus signal bundle between one master and the banked memory controller:
// req/gnt arbitration, start/rdy transfer handshake, abort and per-bank busy flags.
interface simple_bus_mem_ctrl_if #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int NUM_BANKS = 2
);
   logic                 req;
   logic                 gnt;
   logic                 start;
   logic [1:0]           mode;
   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    wdata;
   logic [DATA_W-1:0]    rdata;
   logic                 rdy;
   logic                 err;
   logic                 abort;
   logic [NUM_BANKS-1:0] busy_banks;

   modport master (
      output req, start, mode, addr, wdata, abort,
      input  gnt, rdata, rdy, err, busy_banks
   );

   modport slave (
      input  req, start, mode, addr, wdata, abort,
      output gnt, rdata, rdy, err, busy_banks
   );
endinterface

// File: rtl/simple_bus_mem_ctrl.sv
// Banked simple_bus memory slave: address decode, fixed-latency access, error response.
// Define SIMPLE_BUS_MEM_CTRL_ABORT_EN to let abort kill a transfer while in ACCESS.
module simple_bus_mem_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int NUM_BANKS  = 2,
   parameter int BANK_WORDS = 128,
   parameter int ACCESS_LAT = 10
) (
   input logic                   clk,
   input logic                   rst,
   simple_bus_mem_ctrl_if.slave  bus
);
   localparam int OFF_W  = $clog2(BANK_WORDS);
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int TOTAL  = NUM_BANKS * BANK_WORDS;
   localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int CNT_W  = $clog2(ACCESS_LAT + 1);
   localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W + 1)'(TOTAL);

   typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 gnt_q, gnt_d;
   logic                 rdy_q, rdy_d;
   logic                 err_q, err_d;
   logic                 fail_q, fail_d;
   logic                 wr_q, wr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [BANK_W-1:0]    bank_q, bank_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic [NUM_BANKS-1:0] busy_q, busy_d;
   logic                 mem_we;
   logic                 req_bad;
   logic                 abort_hit;

   logic [DATA_W-1:0]    mem_q [TOTAL];

   // Banks are contiguous, so mem[bank][addr mod BANK_WORDS] is simply mem[addr].
   assign req_bad = ({1'b0, bus.addr} >= TOTAL_W) || bus.mode[1];

`ifdef SIMPLE_BUS_MEM_CTRL_ABORT_EN
   assign abort_hit = (state_q == ACCESS) && bus.abort;
`else
   logic abort_unused;
   assign abort_unused = bus.abort;
   assign abort_hit    = 1'b0;
`endif

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      bank_d  = bank_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req) state_d = GRANT;
         end
         GRANT: begin
            if (bus.start) begin
               wr_d    = (bus.mode == 2'b01);
               idx_d   = bus.addr[IDX_W-1:0];
               bank_d  = BANK_W'(bus.addr >> OFF_W);
               wdata_d = bus.wdata;
               if (req_bad) begin
                  fail_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  fail_d  = 1'b0;
                  cnt_d   = CNT_W'(ACCESS_LAT - 1);
                  state_d = ACCESS;
               end
            end else if (!bus.req) begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (abort_hit) begin
               fail_d  = 1'b1;
               state_d = DONE;
            end else if (cnt_q == '0) begin
               fail_d  = 1'b0;
               state_d = DONE;
               if (wr_q) mem_we  = 1'b1;
               else      rdata_d = mem_q[idx_q];
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = bus.req ? GRANT : IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are registered: gnt/busy follow the state being entered, rdy/err the DONE cycle.
      gnt_d  = (state_d != IDLE);
      rdy_d  = (state_q == DONE);
      err_d  = (state_q == DONE) && fail_q;
      busy_d = (state_d == ACCESS) ? (NUM_BANKS'(1) << bank_d) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gnt_q   <= 1'b0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         fail_q  <= 1'b0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         bank_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         bank_q  <= bank_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
      end
   end

   // NOTE: storage has no reset; a reset mid-ACCESS drops state_q so the write never fires.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[idx_q] <= wdata_q;
   end

   assign bus.gnt        = gnt_q;
   assign bus.rdy        = rdy_q;
   assign bus.err        = err_q;
   assign bus.rdata      = rdata_q;
   assign bus.busy_banks = busy_q;
endmodule

// File: tb/tb_simple_bus_mem_ctrl.sv
// Directed bench: default two-bank controller (u0) plus a one-bank instance (u1) for range errors.
module tb_simple_bus_mem_ctrl;
   logic       clk;
   logic       rst;
   logic [1:0] req_v, start_v, abort_v;
   logic [1:0] mode_v;
   logic [7:0] addr_v, wdata_v;
   int         pass, total;

   simple_bus_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8), .NUM_BANKS(2)) b0 ();
   simple_bus_mem_ctrl_if #(.ADDR_W(8), .DATA_W(8), .NUM_BANKS(1)) b1 ();

   assign b0.req   = req_v[0];
   assign b0.start = start_v[0];
   assign b0.abort = abort_v[0];
   assign b0.mode  = mode_v;
   assign b0.addr  = addr_v;
   assign b0.wdata = wdata_v;
   assign b1.req   = req_v[1];
   assign b1.start = start_v[1];
   assign b1.abort = abort_v[1];
   assign b1.mode  = mode_v;
   assign b1.addr  = addr_v;
   assign b1.wdata = wdata_v;

   simple_bus_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .NUM_BANKS(2), .BANK_WORDS(128), .ACCESS_LAT(10))
      u0 (.clk(clk), .rst(rst), .bus(b0));
   simple_bus_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .NUM_BANKS(1), .BANK_WORDS(128), .ACCESS_LAT(10))
      u1 (.clk(clk), .rst(rst), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One transfer from GRANT; lat counts edges from the start edge to the rdy edge (-1 on timeout).
   task automatic xfer(input int sel, input logic [1:0] mode, input logic [7:0] addr,
                       input logic [7:0] wdata, input int abort_at, input int drop_at,
                       output int lat, output logic err, output logic [7:0] rd,
                       output logic [1:0] busy1st);
      mode_v = mode; addr_v = addr; wdata_v = wdata; start_v[sel] = 1'b1;
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
      lat = -1; err = 1'bx; rd = 8'hxx; busy1st = 2'bxx;
      for (int k = 1; k <= 40; k++) begin
         if (k == abort_at) abort_v[sel] = 1'b1;
         if (k == drop_at) req_v[sel] = 1'b0;
         @(posedge clk); #1;
         abort_v[sel] = 1'b0;
         if (k == 1) busy1st = sel ? {1'b0, b1.busy_banks} : b0.busy_banks;
         if (sel ? b1.rdy : b0.rdy) begin
            lat = k;
            err = sel ? b1.err : b0.err;
            rd  = sel ? b1.rdata : b0.rdata;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_v = '0; start_v = '0; abort_v = '0;
      mode_v = '0; addr_v = '0; wdata_v = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (b0.gnt !== 1'b0) $display("FAIL rst_gnt: got %b expected 0", b0.gnt); else pass++;
      total++; if (b0.rdy !== 1'b0) $display("FAIL rst_rdy: got %b expected 0", b0.rdy); else pass++;
      total++; if (b0.err !== 1'b0) $display("FAIL rst_err: got %b expected 0", b0.err); else pass++;
      total++; if (b0.rdata !== 8'h00) $display("FAIL rst_rdata: got %h expected 00", b0.rdata); else pass++;
      total++; if (b0.busy_banks !== 2'b00) $display("FAIL rst_busy: got %b expected 00", b0.busy_banks); else pass++;
      rst = 1'b0;
      req_v[0] = 1'b1;
      @(posedge clk); #1;
      total++; if (b0.gnt !== 1'b1) $display("FAIL grant_after_req: got %b expected 1", b0.gnt); else pass++;
   endtask

   task automatic test_bank0();
      int lat; logic err; logic [7:0] rd; logic [1:0] busy;
      xfer(0, 2'b01, 8'h10, 8'hA5, 0, 0, lat, err, rd, busy);
      total++; if (lat !== 11) $display("FAIL wr10_lat: got %0d expected 11", lat); else pass++;
      total++; if (err !== 1'b0) $display("FAIL wr10_err: got %b expected 0", err); else pass++;
      total++; if (busy !== 2'b01) $display("FAIL wr10_busy: got %b expected 01", busy); else pass++;
      @(posedge clk); #1;
      total++; if (b0.rdy !== 1'b0) $display("FAIL rdy_one_cycle: got %b expected 0", b0.rdy); else pass++;
      xfer(0, 2'b00, 8'h10, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (lat !== 11) $display("FAIL rd10_lat: got %0d expected 11", lat); else pass++;
      total++; if (rd !== 8'hA5) $display("FAIL rd10_data: got %h expected a5", rd); else pass++;
      total++; if (busy !== 2'b01) $display("FAIL rd10_busy: got %b expected 01", busy); else pass++;
   endtask

   task automatic test_bank1();
      int lat; logic err; logic [7:0] rd; logic [1:0] busy;
      xfer(0, 2'b01, 8'h05, 8'h77, 0, 0, lat, err, rd, busy);
      total++; if (b0.rdata !== 8'hA5) $display("FAIL rdata_hold_on_write: got %h expected a5", b0.rdata); else pass++;
      xfer(0, 2'b01, 8'h85, 8'h3C, 0, 0, lat, err, rd, busy);
      total++; if (busy !== 2'b10) $display("FAIL wr85_busy: got %b expected 10", busy); else pass++;
      total++; if (lat !== 11) $display("FAIL wr85_lat: got %0d expected 11", lat); else pass++;
      xfer(0, 2'b00, 8'h85, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (rd !== 8'h3C) $display("FAIL rd85_data: got %h expected 3c", rd); else pass++;
      xfer(0, 2'b00, 8'h05, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (rd !== 8'h77) $display("FAIL rd05_untouched: got %h expected 77", rd); else pass++;
   endtask

   task automatic test_errors();
      int lat; logic err; logic [7:0] rd; logic [1:0] busy;
      xfer(0, 2'b10, 8'h00, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (lat !== 1) $display("FAIL mode10_lat: got %0d expected 1", lat); else pass++;
      total++; if (err !== 1'b1) $display("FAIL mode10_err: got %b expected 1", err); else pass++;
      total++; if (busy !== 2'b00) $display("FAIL mode10_busy: got %b expected 00", busy); else pass++;
      total++; if (rd !== 8'h77) $display("FAIL mode10_rdata_hold: got %h expected 77", rd); else pass++;
      xfer(0, 2'b11, 8'h10, 8'hEE, 0, 0, lat, err, rd, busy);
      total++; if (err !== 1'b1) $display("FAIL mode11_err: got %b expected 1", err); else pass++;
      xfer(0, 2'b00, 8'h10, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (rd !== 8'hA5) $display("FAIL mode11_no_write: got %h expected a5", rd); else pass++;
   endtask

   task automatic test_range_1bank();
      int lat; logic err; logic [7:0] rd; logic [1:0] busy;
      req_v[1] = 1'b1;
      @(posedge clk); #1;
      xfer(1, 2'b01, 8'h40, 8'h11, 0, 0, lat, err, rd, busy);
      total++; if (busy !== 2'b01) $display("FAIL u1_busy: got %b expected 01", busy); else pass++;
      xfer(1, 2'b01, 8'hC0, 8'h99, 0, 0, lat, err, rd, busy);
      total++; if (lat !== 1) $display("FAIL u1_c0_lat: got %0d expected 1", lat); else pass++;
      total++; if (err !== 1'b1) $display("FAIL u1_c0_err: got %b expected 1", err); else pass++;
      xfer(1, 2'b10, 8'h00, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (lat !== 1 || err !== 1'b1) $display("FAIL u1_mode10: got lat %0d err %b expected lat 1 err 1", lat, err); else pass++;
      xfer(1, 2'b00, 8'h40, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (rd !== 8'h11) $display("FAIL u1_c0_no_alias: got %h expected 11", rd); else pass++;
      req_v[1] = 1'b0;
   endtask

   task automatic test_abort();
      int lat; logic err; logic [7:0] rd; logic [1:0] busy;
      xfer(0, 2'b01, 8'h20, 8'h42, 0, 0, lat, err, rd, busy);
      xfer(0, 2'b01, 8'h20, 8'hFF, 3, 0, lat, err, rd, busy);
`ifdef SIMPLE_BUS_MEM_CTRL_ABORT_EN
      total++; if (lat !== 4) $display("FAIL abort_lat: got %0d expected 4", lat); else pass++;
      total++; if (err !== 1'b1) $display("FAIL abort_err: got %b expected 1", err); else pass++;
      xfer(0, 2'b00, 8'h20, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (rd !== 8'h42) $display("FAIL abort_no_write: got %h expected 42", rd); else pass++;
`else
      total++; if (lat !== 11) $display("FAIL abort_ignored_lat: got %0d expected 11", lat); else pass++;
      total++; if (err !== 1'b0) $display("FAIL abort_ignored_err: got %b expected 0", err); else pass++;
      xfer(0, 2'b00, 8'h20, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (rd !== 8'hFF) $display("FAIL abort_ignored_write: got %h expected ff", rd); else pass++;
`endif
   endtask

   task automatic test_req_drop();
      int lat; logic err; logic [7:0] rd; logic [1:0] busy;
      xfer(0, 2'b00, 8'h85, 8'h00, 0, 2, lat, err, rd, busy);
      total++; if (lat !== 11 || rd !== 8'h3C) $display("FAIL req_drop_xfer: got lat %0d data %h expected lat 11 data 3c", lat, rd); else pass++;
      total++; if (b0.gnt !== 1'b0) $display("FAIL req_drop_gnt: got %b expected 0", b0.gnt); else pass++;
      req_v[0] = 1'b1;
      @(posedge clk); #1;
      total++; if (b0.gnt !== 1'b1) $display("FAIL regrant: got %b expected 1", b0.gnt); else pass++;
   endtask

   task automatic test_reset_mid_access();
      int lat; logic err; logic [7:0] rd; logic [1:0] busy;
      logic saw_rdy;
      xfer(0, 2'b01, 8'h30, 8'h12, 0, 0, lat, err, rd, busy);
      mode_v = 2'b01; addr_v = 8'h30; wdata_v = 8'hEE; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++; if (b0.busy_banks !== 2'b01) $display("FAIL pre_rst_busy: got %b expected 01", b0.busy_banks); else pass++;
      #2 rst = 1'b1;
      #1;
      total++; if ({b0.gnt, b0.rdy, b0.err, b0.busy_banks, b0.rdata} !== 13'h0)
         $display("FAIL async_rst_outputs: got gnt %b rdy %b err %b busy %b rdata %h expected all 0",
                  b0.gnt, b0.rdy, b0.err, b0.busy_banks, b0.rdata);
      else pass++;
      saw_rdy = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (b0.rdy) saw_rdy = 1'b1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      total++; if (b0.gnt !== 1'b1) $display("FAIL post_rst_regrant: got %b expected 1", b0.gnt); else pass++;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (b0.rdy) saw_rdy = 1'b1;
      end
      total++; if (saw_rdy !== 1'b0) $display("FAIL rst_no_rdy: got %b expected 0", saw_rdy); else pass++;
      xfer(0, 2'b00, 8'h30, 8'h00, 0, 0, lat, err, rd, busy);
      total++; if (rd !== 8'h12) $display("FAIL rst_write_dropped: got %h expected 12", rd); else pass++;
   endtask

   initial begin
      pass = 0;
      total = 0;
      test_reset();
      test_bank0();
      test_bank1();
      test_errors();
      test_range_1bank();
      test_abort();
      test_req_drop();
      test_reset_mid_access();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
